// File: rtl/stopwatch_pkg.sv
// Stopwatch lap controller shared types: FSM state encoding and parameter defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stopwatch_pkg;

    localparam int TIME_W_DEF    = 16;
    localparam int LAP_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_RECALL = 2'd3
    } state_t;

endpackage

// File: rtl/lap_buffer.sv
// Circular lap register file: write at pointer, clear, read by age (0 = newest).
// Latency: write/clear/count take effect on the next edge; read is combinational.
// Backpressure: none; a write when full overwrites the oldest entry.
module lap_buffer
    import stopwatch_pkg::*;
#(
    parameter int TIME_W    = TIME_W_DEF,
    parameter int LAP_DEPTH = LAP_DEPTH_DEF,
    localparam int PTR_W    = $clog2(LAP_DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [TIME_W-1:0] wr_dat,
    input  logic              clr_en,
    input  logic [PTR_W-1:0]  rd_age,
    output logic [TIME_W-1:0] rd_dat,
    output logic [PTR_W:0]    count
);

    localparam logic [PTR_W:0] FULL = LAP_DEPTH[PTR_W:0];

    logic [TIME_W-1:0] mem [LAP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr_en) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (count != FULL) begin
                count <= count + 1'b1;
            end
        end
    end

    // Entry contents are never reset; count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en && !clr_en) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Power-of-two depth lets the pointer arithmetic wrap naturally.
    assign rd_idx = wr_ptr - 1'b1 - rd_age;
    assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch control FSM with lap capture and recall over a circular lap buffer.
// Latency: all outputs registered, 1 cycle after the sampled button pulse.
// Backpressure: none; every button pulse is consumed in the cycle it arrives.
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TIME_W    = TIME_W_DEF,
    parameter int LAP_DEPTH = LAP_DEPTH_DEF,
    localparam int SEL_W    = $clog2(LAP_DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        btn_pedge,
    input  logic [TIME_W-1:0] time_value,
    output logic              run_en,
    output logic              clr,
    output logic [TIME_W-1:0] disp_value,
    output logic [SEL_W:0]    lap_count,
    output logic [SEL_W-1:0]  lap_sel,
    output logic [1:0]        state
);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                clr_d;
    logic                lap_wr, lap_clr;
    logic                ev_start, ev_clear, ev_lap;
    logic [TIME_W-1:0]   rd_dat;

    // Fixed priority: only the highest-priority pulse is honoured, even if it is a no-op in this state.
    assign ev_start = btn_pedge[0];
    assign ev_clear = btn_pedge[2] & ~btn_pedge[0];
    assign ev_lap   = btn_pedge[1] & ~btn_pedge[0] & ~btn_pedge[2];

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        clr_d   = 1'b0;
        lap_wr  = 1'b0;
        lap_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ev_start) begin
                    state_d = ST_RUN;
                end else if (ev_clear) begin
                    clr_d   = 1'b1;
                    lap_clr = 1'b1;
                    sel_d   = '0;
                end
            end
            ST_RUN: begin
                if (ev_start) begin
                    state_d = ST_PAUSE;
                end else if (ev_lap) begin
                    lap_wr = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (ev_start) begin
                    state_d = ST_RUN;
                end else if (ev_clear) begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                    lap_clr = 1'b1;
                    sel_d   = '0;
                end else if (ev_lap && lap_count != '0) begin
                    state_d = ST_RECALL;
                    sel_d   = '0;
                end
            end
            ST_RECALL: begin
                if (ev_start || ev_clear) begin
                    state_d = ST_PAUSE;
                end else if (ev_lap) begin
                    if ({1'b0, sel_q} + 1'b1 == lap_count) begin
                        sel_d = '0;
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            clr        <= 1'b0;
            run_en     <= 1'b0;
            disp_value <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            clr        <= clr_d;
            run_en     <= (state_d == ST_RUN);
            disp_value <= (state_d == ST_RECALL) ? rd_dat : time_value;
        end
    end

    lap_buffer #(
        .TIME_W    (TIME_W),
        .LAP_DEPTH (LAP_DEPTH)
    ) u_lap_buffer (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (lap_wr),
        .wr_dat  (time_value),
        .clr_en  (lap_clr),
        .rd_age  (sel_d),
        .rd_dat  (rd_dat),
        .count   (lap_count)
    );

    assign lap_sel = sel_q;
    assign state   = state_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Scoreboard bench for stopwatch_lap_ctrl: directed scenarios then random button traffic.
// Expected outputs come from a queue-based lap model; a monitor compares after each edge.
module tb_stopwatch_lap_ctrl;

    localparam int DEPTH = 4;

    typedef struct {
        logic [1:0]  st;
        logic        run;
        logic        clr;
        logic [15:0] disp;
        logic [2:0]  cnt;
        logic [1:0]  sel;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [2:0]  btn_pedge;
    logic [15:0] time_value;
    logic        run_en;
    logic        clr;
    logic [15:0] disp_value;
    logic [2:0]  lap_count;
    logic [1:0]  lap_sel;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    exp_t        exp_q[$];
    logic [15:0] laps[$];
    int          m_st  = 0;
    int          m_sel = 0;

    stopwatch_lap_ctrl #(.TIME_W(16), .LAP_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_pedge  (btn_pedge),
        .time_value (time_value),
        .run_en     (run_en),
        .clr        (clr),
        .disp_value (disp_value),
        .lap_count  (lap_count),
        .lap_sel    (lap_sel),
        .state      (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
        end
    endtask

    // Reference behaviour: laps[0] is the newest capture; m_sel is an age into that list.
    task automatic model_step(input logic [2:0] b, input logic [15:0] tv);
        exp_t e;
        int   ev;
        ev    = b[0] ? 0 : b[2] ? 2 : b[1] ? 1 : -1;
        e.clr = 1'b0;
        case (m_st)
            0: if (ev == 0) m_st = 1;
               else if (ev == 2) begin e.clr = 1'b1; laps.delete(); m_sel = 0; end
            1: if (ev == 0) m_st = 2;
               else if (ev == 1) begin
                   laps.push_front(tv);
                   if (laps.size() > DEPTH) void'(laps.pop_back());
               end
            2: if (ev == 0) m_st = 1;
               else if (ev == 2) begin e.clr = 1'b1; laps.delete(); m_sel = 0; m_st = 0; end
               else if (ev == 1 && laps.size() > 0) begin m_st = 3; m_sel = 0; end
            default: if (ev == 1) m_sel = (m_sel + 1) % laps.size();
                     else if (ev == 0 || ev == 2) m_st = 2;
        endcase
        e.st   = 2'(m_st);
        e.run  = (m_st == 1);
        e.disp = (m_st == 3) ? laps[m_sel] : tv;
        e.cnt  = 3'(laps.size());
        e.sel  = 2'(m_sel);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [2:0] b, input logic [15:0] tv);
        @(negedge clk);
        btn_pedge  = b;
        time_value = tv;
        model_step(b, tv);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_run_en"}, 32'(run_en), 0);
        chk({tag, "_clr"}, 32'(clr), 0);
        chk({tag, "_disp"}, 32'(disp_value), 0);
        chk({tag, "_lap_count"}, 32'(lap_count), 0);
        chk({tag, "_lap_sel"}, 32'(lap_sel), 0);
    endtask

    // Short asynchronous reset pulse placed between clock edges.
    task automatic mid_reset();
        @(posedge clk);
        #3;
        reset_n   = 1'b0;
        btn_pedge = 3'b000;
        #1;
        chk_reset_vals("async_rst");
        m_st  = 0;
        m_sel = 0;
        laps.delete();
        #2;
        reset_n = 1'b1;
        model_step(btn_pedge, time_value);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state", 32'(state), 32'(e.st));
                chk("run_en", 32'(run_en), 32'(e.run));
                chk("clr", 32'(clr), 32'(e.clr));
                chk("disp_value", 32'(disp_value), 32'(e.disp));
                chk("lap_count", 32'(lap_count), 32'(e.cnt));
                chk("lap_sel", 32'(lap_sel), 32'(e.sel));
            end
        end
    end

    initial begin : stimulus
        int  wait_cnt;
        logic [2:0] b;
        reset_n    = 1'b0;
        btn_pedge  = 3'b000;
        time_value = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("por");
        @(negedge clk);
        reset_n = 1'b1;
        model_step(3'b000, 16'h0000);

        // start, then pause
        step(3'b001, 16'h0000);
        step(3'b000, 16'h0001);
        step(3'b001, 16'h0002);

        // two laps, recall and wrap
        step(3'b001, 16'h0010);
        step(3'b010, 16'h0123);
        step(3'b000, 16'h0200);
        step(3'b010, 16'h0456);
        step(3'b001, 16'h0500);
        step(3'b010, 16'h0501);
        step(3'b010, 16'h0502);
        step(3'b010, 16'h0503);
        step(3'b001, 16'h0504);

        // clear from pause with laps present; recall then refused
        step(3'b100, 16'h0600);
        step(3'b000, 16'h0601);
        step(3'b001, 16'h0602);
        step(3'b001, 16'h0603);
        step(3'b010, 16'h0604);

        // overflow the lap buffer, recall the newest four
        step(3'b001, 16'h0700);
        for (int i = 1; i <= 5; i++) step(3'b010, 16'(i));
        step(3'b001, 16'h0800);
        for (int i = 0; i < 5; i++) step(3'b010, 16'h0900);

        // all buttons at once from pause
        step(3'b001, 16'h0a00);
        step(3'b111, 16'h0a01);
        step(3'b000, 16'h0a02);

        // async reset in recall
        step(3'b001, 16'h0b00);
        step(3'b010, 16'h0b01);
        step(3'b000, 16'h0b02);
        mid_reset();

        for (int i = 0; i < 800; i++) begin
            b = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            step(b, 16'($urandom));
        end
        step(3'b000, 16'h0000);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
